// File: rtl/bt_pkg.sv
// Shared constants for the Bluetooth UART link: baud timing, receiver state
// encoding and the command header bytes consumed by bt_decoder.
package bt_pkg;

   localparam int unsigned CLK_FREQ     = 25_000_000;
   localparam int unsigned BAUD         = 9600;
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_e;

   // Command header bytes; a header is followed by its argument bytes.
   localparam logic [7:0] CMD_MOVE = 8'hC1;
   localparam logic [7:0] CMD_STOP = 8'hC2;
   localparam logic [7:0] CMD_HOME = 8'hC3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value
// so an idle-high line does not look like a falling edge coming out of reset.
module sync_2ff #(
   parameter int unsigned       WIDTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module link. Samples mid-bit from the
// start-bit midpoint and emits one-cycle rx_valid / frame_err strobes.
module bt_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = bt_pkg::CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);
   import bt_pkg::*;

   localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_e        state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [2:0]       bit_idx_q,   bit_idx_d;
   logic [7:0]       shift_q,     shift_d;
   logic [7:0]       rx_byte_q,   rx_byte_d;
   logic             rx_valid_q,  rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             rx_s;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_byte_d   = rx_byte_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = RX_START;
         end
         RX_START: begin
            // A start bit still low at its midpoint is genuine; anything else is a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            // A break holds the line low; wait it out so it reports only once.
            cnt_d = '0;
            if (rx_s) state_d = RX_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_byte_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_bt_uart_rx.sv
// Randomized bench for bt_uart_rx: frames are modelled as a queue of expected
// events (good byte or framing error) and matched against observed strobes.
module tb_bt_uart_rx;

   localparam int CPB     = 16;
   localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fall_cyc = 0;
   logic       prev_strobe = 1'b0;
   logic [7:0] last_good = 8'h00;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   bt_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every strobe becomes an event {is_err, rx_byte}; a framing error must leave rx_byte untouched.
   always @(negedge clk) begin
      if (rx_valid || frame_err) begin
         chk("strobe_excl", {31'd0, rx_valid & frame_err}, 32'd0);
         chk("strobe_consec", {31'd0, prev_strobe}, 32'd0);
         got_q.push_back({frame_err, rx_byte});
         if (rx_valid) begin
            int lat;
            lat = cyc - fall_cyc;
            chk("latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? LAT_NOM : lat, LAT_NOM);
         end
      end
      prev_strobe = rx_valid | frame_err;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      wait_cyc(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      fall_cyc = cyc;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(CPB);
      end
      rx = stop_ok;
      if (stop_ok) begin
         exp_q.push_back({1'b0, b});
         last_good = b;
      end else begin
         exp_q.push_back({1'b1, last_good});
      end
      wait_cyc(CPB);
   endtask

   task automatic compare_events(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_event"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      wait_cyc(3);
      chk("rst_byte", {24'd0, rx_byte}, 32'h00);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      idle(20);

      // Single good frame, busy observed mid-frame
      fork
         send_frame(8'hC1, 1'b1);
         begin
            wait_cyc(4 * CPB);
            chk("c1_busy_mid", {31'd0, busy}, 32'd1);
         end
      join
      idle(20);
      compare_events("c1");
      chk("c1_byte", {24'd0, rx_byte}, 32'hC1);
      chk("c1_busy_after", {31'd0, busy}, 32'd0);

      // Back-to-back move command, no gap
      send_frame(8'hC1, 1'b1);
      send_frame(8'h2D, 1'b1);
      send_frame(8'h25, 1'b1);
      idle(20);
      compare_events("b2b");
      chk("b2b_byte", {24'd0, rx_byte}, 32'h25);

      // Short glitch is rejected
      rx = 1'b0;
      wait_cyc(4);
      idle(40);
      compare_events("glitch");
      chk("glitch_busy", {31'd0, busy}, 32'd0);

      // Framing error followed by a stuck-low line
      send_frame(8'hC1, 1'b1);
      send_frame(8'h2D, 1'b0);
      rx = 1'b0;
      wait_cyc(40);
      chk("ferr_busy_low", {31'd0, busy}, 32'd1);
      chk("ferr_byte", {24'd0, rx_byte}, 32'hC1);
      idle(CPB);
      chk("ferr_busy_high", {31'd0, busy}, 32'd0);
      compare_events("ferr");

      // Reset in the middle of data bit 4 of 0xC3; the sender abandons the frame
      rx = 1'b0;
      fall_cyc = cyc;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'hC3 >> i);
         wait_cyc(CPB);
      end
      rx = 1'b0;
      wait_cyc(CPB / 2);
      reset = 1'b1;
      rx    = 1'b1;
      wait_cyc(1);
      chk("midrst_byte", {24'd0, rx_byte}, 32'h00);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      last_good = 8'h00;
      idle(30);
      compare_events("midrst");
      send_frame(8'h0F, 1'b1);
      idle(20);
      compare_events("post_rst");
      chk("post_rst_byte", {24'd0, rx_byte}, 32'h0F);

      // Random frames: random data, occasional bad stop bits, random gaps (including none)
      for (int f = 0; f < 30; f++) begin
         logic [7:0] b;
         logic       ok;
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok);
         if (!ok) begin
            rx = 1'b0;
            wait_cyc($urandom_range(0, 30));
            idle(CPB + $urandom_range(0, 5));
         end else begin
            idle($urandom_range(0, 3));
         end
      end
      idle(20);
      compare_events("rand");
      chk("rand_byte", {24'd0, rx_byte}, {24'd0, last_good});
      chk("rand_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
